// File: rtl/spi_master_pkg.sv
// ============================================================================
// Module : spi_master_pkg
// Brief  : Shared types and defaults for the SPI master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_master_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CLK_DIV_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  // Mode word is {CPOL, CPHA}
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ============================================================================
// Module : spi_clk_gen
// Brief  : Half-period counter producing alternating leading/trailing strobes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_lead_stb,
  output logic o_trail_stb
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          w_tick;

  assign w_tick      = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_lead_stb  = w_tick && !r_phase;
  assign o_trail_stb = w_tick &&  r_phase;

  // Phase restarts on every enable so the first strobe is always a leading edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module : spi_master
// Brief  : Single-slave SPI master, all four CPOL/CPHA modes, registered outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master
  import spi_master_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CLK_DIV    = CLK_DIV_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  CPOL,
  input  logic                  CPHA,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  sclk,
  output logic                  cs_n,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH);

  state_e                r_state, w_next;
  spi_mode_e             r_mode;
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_smp_done;
  logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic                  r_sclk, r_cs_n, r_mosi, r_busy, r_done;
  logic                  w_lead, w_trail, w_sample, w_last_smp, w_xfer_end;
  logic                  w_cnt_end, w_xfer_en, w_cpha;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_xfer_en),
    .o_lead_stb  (w_lead),
    .o_trail_stb (w_trail)
  );

  assign w_xfer_en  = (r_state == ST_XFER);
  assign w_cpha     = r_mode[0];
  assign w_cnt_end  = (r_cnt == CW'(CLK_DIV - 1));
  assign w_sample   = w_cpha ? w_trail : w_lead;
  assign w_last_smp = w_sample && (r_bit_cnt == BW'(DATA_WIDTH - 1));
  // CPHA=0 takes its last sample on a leading edge; the transfer still ends on the trailing edge
  assign w_xfer_end = w_trail && (r_smp_done || w_last_smp);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)      w_next = ST_SETUP;
      ST_SETUP: if (w_cnt_end)  w_next = ST_XFER;
      ST_XFER:  if (w_xfer_end) w_next = ST_HOLD;
      ST_HOLD:  if (w_cnt_end)  w_next = ST_GAP;
      ST_GAP:   if (w_cnt_end)  w_next = ST_IDLE;
      default:                  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE0;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_smp_done <= 1'b0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if ((r_state == ST_SETUP || r_state == ST_HOLD || r_state == ST_GAP) && !w_cnt_end)
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;

      case (r_state)
        ST_IDLE: begin
          r_sclk <= CPOL;
          r_cs_n <= 1'b1;
          r_mosi <= 1'b0;
          if (start) begin
            r_mode     <= spi_mode_e'({CPOL, CPHA});
            r_tx       <= tx_data;
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_mosi     <= CPHA ? 1'b0 : tx_data[DATA_WIDTH-1];
            r_bit_cnt  <= '0;
            r_smp_done <= 1'b0;
          end
        end
        ST_XFER: begin
          if (w_lead || w_trail) r_sclk <= ~r_sclk;
          if (w_sample) begin
            r_rx      <= {r_rx[DATA_WIDTH-2:0], miso};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          if (w_last_smp) r_smp_done <= 1'b1;
          if (!w_cpha && w_trail && !w_xfer_end) begin
            r_mosi <= r_tx[DATA_WIDTH-2];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          end
          if (w_cpha && w_lead) begin
            r_mosi <= r_tx[DATA_WIDTH-1];
            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
          end
        end
        ST_HOLD: begin
          if (w_cnt_end) begin
            r_cs_n    <= 1'b1;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
            r_mosi    <= 1'b0;
          end
        end
        ST_GAP: begin
          if (w_cnt_end) r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module : tb_spi_master
// Brief  : Directed bench for spi_master with a behavioural echo slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       CPOL = 1'b0;
  logic       CPHA = 1'b0;
  logic       busy, done, sclk, cs_n, mosi;
  logic [7:0] rx_data;
  logic       miso;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int done_cnt = 0;

  // Behavioural slave state
  logic       m_cpol = 1'b0;
  logic       m_cpha = 1'b0;
  logic [7:0] s_tx_word = 8'h00;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       s_miso = 1'b0;

  spi_master dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .tx_data (tx_data),
    .CPOL    (CPOL),
    .CPHA    (CPHA),
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  always @(posedge sclk) if (cs_n === 1'b0) rise_cnt++;
  always @(negedge sclk) if (cs_n === 1'b0) fall_cnt++;

  assign miso = (cs_n === 1'b0) ? s_miso : 1'b0;

  always @(negedge cs_n) begin
    s_sh = s_tx_word;
    s_rx = 8'h00;
    if (!m_cpha) s_miso = s_sh[7];
  end

  always @(sclk) begin
    if (cs_n === 1'b0) begin
      if (sclk !== m_cpol) begin
        if (!m_cpha) s_rx = {s_rx[6:0], mosi};
        else begin s_miso = s_sh[7]; s_sh = {s_sh[6:0], 1'b0}; end
      end else begin
        if (!m_cpha) begin s_sh = {s_sh[6:0], 1'b0}; s_miso = s_sh[7]; end
        else s_rx = {s_rx[6:0], mosi};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic cp, input logic ch, input logic [7:0] mtx, input logic [7:0] stx,
                        input bit keep, input string tag,
                        output int c_a, output int r0, output int f0, output int d0);
    int w;
    CPOL = cp; CPHA = ch; m_cpol = cp; m_cpha = ch;
    tx_data = mtx; s_tx_word = stx;
    w = 0;
    while (busy !== 1'b0 && w < 50) begin @(negedge clk); w++; end
    chk({tag, ":idle_wait"}, 32'(busy === 1'b0), 32'd1);
    @(negedge clk);
    chk({tag, ":idle_sclk"}, 32'(sclk), 32'(cp));
    chk({tag, ":idle_csn"}, 32'(cs_n), 32'd1);
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt;
    start = 1'b1;
    c_a = cyc;
    @(negedge clk);
    if (!keep) start = 1'b0;
    chk({tag, ":acc_busy"}, 32'(busy), 32'd1);
    chk({tag, ":acc_csn"}, 32'(cs_n), 32'd0);
    chk({tag, ":acc_sclk"}, 32'(sclk), 32'(cp));
    chk({tag, ":acc_mosi"}, 32'(mosi), ch ? 32'd0 : 32'(mtx[7]));
  endtask

  task automatic finish(input logic cp, input logic [7:0] mtx, input logic [7:0] stx, input string tag,
                        input int c_a, input int r0, input int f0, input int d0, output int cd);
    bit got;
    int drops;
    got = 0; drops = 0; cd = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; cd = cyc; end
      else if (busy !== 1'b1) drops++;
    end
    chk({tag, ":done_seen"}, 32'(got), 32'd1);
    chk({tag, ":latency"}, 32'(cd - c_a), 32'd73);
    chk({tag, ":busy_drop"}, 32'(drops), 32'd0);
    chk({tag, ":rx_data"}, 32'(rx_data), 32'(stx));
    chk({tag, ":slave_rx"}, 32'(s_rx), 32'(mtx));
    chk({tag, ":done_csn"}, 32'(cs_n), 32'd1);
    chk({tag, ":done_sclk"}, 32'(sclk), 32'(cp));
    chk({tag, ":rises"}, 32'(rise_cnt - r0), 32'd8);
    chk({tag, ":falls"}, 32'(fall_cnt - f0), 32'd8);
    @(negedge clk);
    chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    chk({tag, ":done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic xfer(input logic cp, input logic ch, input logic [7:0] mtx, input logic [7:0] stx,
                      input string tag);
    int c_a, r0, f0, d0, cd;
    launch(cp, ch, mtx, stx, 1'b0, tag, c_a, r0, f0, d0);
    finish(cp, mtx, stx, tag, c_a, r0, f0, d0, cd);
  endtask

  initial begin
    int c_a, r0, f0, d0, cd, cd2, hi, w;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst:sclk", 32'(sclk), 32'd0);
    chk("rst:csn", 32'(cs_n), 32'd1);
    chk("rst:mosi", 32'(mosi), 32'd0);
    chk("rst:busy", 32'(busy), 32'd0);
    chk("rst:done", 32'(done), 32'd0);
    chk("rst:rx", 32'(rx_data), 32'd0);
    rst_n = 1'b1;

    // All four modes with the same data
    xfer(1'b0, 1'b0, 8'hA5, 8'h3C, "m0");
    xfer(1'b0, 1'b1, 8'hA5, 8'h3C, "m1");
    xfer(1'b1, 1'b0, 8'hA5, 8'h3C, "m2");
    xfer(1'b1, 1'b1, 8'hA5, 8'h3C, "m3");

    // start pulsed in XFER with a different word must be ignored
    launch(1'b1, 1'b0, 8'h81, 8'h7E, 1'b0, "ign", c_a, r0, f0, d0);
    repeat (30) @(negedge clk);
    tx_data = 8'hFF; CPOL = 1'b0; CPHA = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish(1'b1, 8'h81, 8'h7E, "ign", c_a, r0, f0, d0, cd);
    repeat (100) @(negedge clk);
    chk("ign:single", 32'(done_cnt - d0), 32'd1);
    chk("ign:idle_busy", 32'(busy), 32'd0);

    // Back-to-back with start held high
    launch(1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, "b2b1", c_a, r0, f0, d0);
    finish(1'b0, 8'h00, 8'h5A, "b2b1", c_a, r0, f0, d0, cd);
    tx_data = 8'hFF; s_tx_word = 8'hC3;
    hi = 2; w = 0;
    while (cs_n === 1'b1 && w < 50) begin
      @(negedge clk);
      if (cs_n === 1'b1) hi++;
      w++;
    end
    start = 1'b0;
    chk("b2b:deselect", 32'(hi), 32'd5);
    chk("b2b:busy2", 32'(busy), 32'd1);
    r0 = rise_cnt; f0 = fall_cnt; d0 = done_cnt;
    finish(1'b0, 8'hFF, 8'hC3, "b2b2", cd + 4, r0, f0, d0, cd2);
    chk("b2b:spacing", 32'(cd2 - cd), 32'd77);

    // Asynchronous reset in the middle of the word
    launch(1'b0, 1'b0, 8'h5A, 8'hA5, 1'b0, "abort", c_a, r0, f0, d0);
    w = 0;
    while (rise_cnt - r0 < 3 && w < 200) begin @(negedge clk); w++; end
    chk("abort:reach_bit3", 32'(rise_cnt - r0), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("abort:csn", 32'(cs_n), 32'd1);
    chk("abort:sclk", 32'(sclk), 32'd0);
    chk("abort:busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (90) @(negedge clk);
    chk("abort:no_done", 32'(done_cnt - d0), 32'd0);
    xfer(1'b0, 1'b0, 8'h96, 8'h69, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
